// File: rtl/dcache_arbiter.sv
// Round-robin arbiter sharing one data-cache port between two requesters,
// one transaction in flight, registered outputs, watchdog abort on a hung cache.
module dcache_arbiter #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_en_i,
    input  logic              m0_wren_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_done_o,
    input  logic              m1_en_i,
    input  logic              m1_wren_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_done_o,
    output logic              mem_en_o,
    output logic              mem_wren_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_done_i,
    output logic              busy_o,
    output logic              owner_o,
    output logic              timeout_err_o
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit          WD_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                rr_last_q, rr_last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_wren_q, mem_wren_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
    logic                m0_done_q, m0_done_d;
    logic                m1_done_q, m1_done_d;
    logic                busy_q, busy_d;
    logic                owner_q, owner_d;
    logic                timeout_err_q, timeout_err_d;
    logic                win;
    logic                wd_fire;

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        rr_last_d     = rr_last_q;
        cnt_d         = cnt_q;
        mem_en_d      = mem_en_q;
        mem_wren_d    = mem_wren_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        m0_rdata_d    = m0_rdata_q;
        m1_rdata_d    = m1_rdata_q;
        m0_done_d     = 1'b0;
        m1_done_d     = 1'b0;
        owner_d       = owner_q;
        timeout_err_d = timeout_err_q;
        win           = 1'b0;
        wd_fire       = WD_EN && (cnt_q == CNT_W'(TIMEOUT - 1));

        case (state_q)
            IDLE: begin
                if (m0_en_i || m1_en_i) begin
                    win         = (m0_en_i && m1_en_i) ? ~rr_last_q : m1_en_i;
                    mem_en_d    = 1'b1;
                    mem_wren_d  = win ? m1_wren_i  : m0_wren_i;
                    mem_addr_d  = win ? m1_addr_i  : m0_addr_i;
                    mem_wdata_d = win ? m1_wdata_i : m0_wdata_i;
                    owner_d     = win;
                    rr_last_d   = win;
                    cnt_d       = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (WD_EN) cnt_d = cnt_q + CNT_W'(1);
                // A real completion takes priority over a coincident watchdog expiry
                if (mem_done_i) begin
                    mem_en_d = 1'b0;
                    state_d  = RESP;
                    if (owner_q) m1_done_d = 1'b1;
                    else         m0_done_d = 1'b1;
                    if (!mem_wren_q) begin
                        if (owner_q) m1_rdata_d = mem_rdata_i;
                        else         m0_rdata_d = mem_rdata_i;
                    end
                end else if (wd_fire) begin
                    mem_en_d      = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = RESP;
                    if (owner_q) begin
                        m1_done_d  = 1'b1;
                        m1_rdata_d = '0;
                    end else begin
                        m0_done_d  = 1'b1;
                        m0_rdata_d = '0;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_last_q     <= 1'b1;
            cnt_q         <= '0;
            mem_en_q      <= 1'b0;
            mem_wren_q    <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            m0_rdata_q    <= '0;
            m1_rdata_q    <= '0;
            m0_done_q     <= 1'b0;
            m1_done_q     <= 1'b0;
            busy_q        <= 1'b0;
            owner_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_last_q     <= rr_last_d;
            cnt_q         <= cnt_d;
            mem_en_q      <= mem_en_d;
            mem_wren_q    <= mem_wren_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            m0_rdata_q    <= m0_rdata_d;
            m1_rdata_q    <= m1_rdata_d;
            m0_done_q     <= m0_done_d;
            m1_done_q     <= m1_done_d;
            busy_q        <= busy_d;
            owner_q       <= owner_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign m0_rdata_o    = m0_rdata_q;
    assign m0_done_o     = m0_done_q;
    assign m1_rdata_o    = m1_rdata_q;
    assign m1_done_o     = m1_done_q;
    assign mem_en_o      = mem_en_q;
    assign mem_wren_o    = mem_wren_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign busy_o        = busy_q;
    assign owner_o       = owner_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_dcache_arbiter.sv
// Directed bench for dcache_arbiter: single read, saturated alternation, write,
// watchdog abort, async reset mid-transaction, done/timeout race.
module tb_dcache_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_en, m0_wren, m1_en, m1_wren;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic          m0_done, m1_done;
    logic          mem_en, mem_wren, mem_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy, owner, timeout_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dcache_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_en_i(m0_en), .m0_wren_i(m0_wren), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_rdata_o(m0_rdata), .m0_done_o(m0_done),
        .m1_en_i(m1_en), .m1_wren_i(m1_wren), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_rdata_o(m1_rdata), .m1_done_o(m1_done),
        .mem_en_o(mem_en), .mem_wren_o(mem_wren), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_done_i(mem_done),
        .busy_o(busy), .owner_o(owner), .timeout_err_o(timeout_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        m0_en = 0; m0_wren = 0; m0_addr = '0; m0_wdata = '0;
        m1_en = 0; m1_wren = 0; m1_addr = '0; m1_wdata = '0;
        mem_done = 0; mem_rdata = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_owner", owner, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_done", m1_done, 0);
        rst_n = 1'b1;
        tick();

        // T1: m0 read 0x1000 -> 0xDEAD
        m0_en = 1; m0_wren = 0; m0_addr = 64'h1000;
        tick();
        chk("t1_mem_en", mem_en, 1);
        chk("t1_addr", mem_addr, 64'h1000);
        chk("t1_wren", mem_wren, 0);
        chk("t1_owner", owner, 0);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_mem_en_hold", mem_en, 1);
        chk("t1_no_done", m0_done, 0);
        mem_done = 1; mem_rdata = 64'hDEAD;
        tick();
        chk("t1_mem_en_low", mem_en, 0);
        chk("t1_m0_done", m0_done, 1);
        chk("t1_m1_done", m1_done, 0);
        chk("t1_rdata", m0_rdata, 64'hDEAD);
        mem_done = 0; m0_en = 0;
        tick();
        chk("t1_done_pulse", m0_done, 0);
        chk("t1_idle", busy, 0);
        chk("t1_rdata_keep", m0_rdata, 64'hDEAD);

        // T2: both saturating from reset -> 0,1,0,1
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        m0_en = 1; m0_addr = 64'hA0; m1_en = 1; m1_wren = 0; m1_addr = 64'hB0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_owner", owner, 64'(i % 2));
            chk("t2_addr", mem_addr, (i % 2) ? 64'hB0 : 64'hA0);
            chk("t2_mem_en", mem_en, 1);
            mem_done = 1; mem_rdata = 64'h100 + 64'(i);
            tick();
            chk("t2_own_done", (i % 2) ? m1_done : m0_done, 1);
            chk("t2_other_done", (i % 2) ? m0_done : m1_done, 0);
            chk("t2_rdata", (i % 2) ? m1_rdata : m0_rdata, 64'h100 + 64'(i));
            mem_done = 0;
            tick();
            chk("t2_gap_mem_en", mem_en, 0);
        end
        m0_en = 0; m1_en = 0;
        tick();

        // T3: m1 write 0x2000 <- 0x55, inputs changed mid-transaction are ignored
        m1_en = 1; m1_wren = 1; m1_addr = 64'h2000; m1_wdata = 64'h55; mem_rdata = 64'hBEEF;
        tick();
        chk("t3_owner", owner, 1);
        chk("t3_wren", mem_wren, 1);
        chk("t3_wdata", mem_wdata, 64'h55);
        m1_wdata = 64'h77; m1_addr = 64'h9999;
        tick();
        chk("t3_wdata_hold", mem_wdata, 64'h55);
        chk("t3_addr_hold", mem_addr, 64'h2000);
        mem_done = 1;
        tick();
        chk("t3_m1_done", m1_done, 1);
        chk("t3_m0_done", m0_done, 0);
        chk("t3_rdata_unch", m1_rdata, 64'h103);
        mem_done = 0; m1_en = 0; m1_wren = 0;
        tick();

        // T4: watchdog abort after 4 BUSY cycles
        m0_en = 1; m0_wren = 0; m0_addr = 64'h3000;
        tick();
        chk("t4_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_wait_mem_en", mem_en, 1);
            chk("t4_wait_terr", timeout_err, 0);
        end
        tick();
        chk("t4_abort_mem_en", mem_en, 0);
        chk("t4_terr", timeout_err, 1);
        chk("t4_done", m0_done, 1);
        chk("t4_rdata0", m0_rdata, 0);
        m0_en = 0;
        tick();
        chk("t4_terr_sticky", timeout_err, 1);
        m1_en = 1; m1_addr = 64'h4000;
        tick();
        chk("t4_next_owner", owner, 1);
        mem_done = 1; mem_rdata = 64'h44;
        tick();
        chk("t4_next_done", m1_done, 1);
        chk("t4_next_rdata", m1_rdata, 64'h44);
        chk("t4_terr_still", timeout_err, 1);
        mem_done = 0; m1_en = 0;
        tick();

        // T5: async reset mid-BUSY, then m0 wins first tie
        m1_en = 1; m1_addr = 64'h5000;
        tick();
        chk("t5_owner", owner, 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_mem_en", mem_en, 0);
        chk("t5_rst_terr", timeout_err, 0);
        chk("t5_rst_owner", owner, 0);
        chk("t5_rst_m1_rdata", m1_rdata, 0);
        mem_done = 1;
        tick();
        chk("t5_no_done", m1_done, 0);
        mem_done = 0; m0_en = 1; m0_addr = 64'h6000;
        rst_n = 1'b1;
        tick();
        chk("t5_tie_owner", owner, 0);
        chk("t5_tie_addr", mem_addr, 64'h6000);
        mem_done = 1; mem_rdata = 64'h55AA;
        tick();
        chk("t5_m0_done", m0_done, 1);
        mem_done = 0; m0_en = 0; m1_en = 0;
        tick();

        // T6: spurious mem_done in IDLE, then done racing watchdog expiry
        mem_done = 1;
        tick();
        chk("t6_spur_busy", busy, 0);
        chk("t6_spur_mem_en", mem_en, 0);
        chk("t6_spur_m0_done", m0_done, 0);
        chk("t6_spur_m1_done", m1_done, 0);
        mem_done = 0;
        m1_en = 1; m1_wren = 0; m1_addr = 64'h7000;
        tick();
        chk("t6_owner", owner, 1);
        tick(); tick(); tick();
        chk("t6_still_busy", mem_en, 1);
        mem_done = 1; mem_rdata = 64'h66;
        tick();
        chk("t6_done", m1_done, 1);
        chk("t6_rdata", m1_rdata, 64'h66);
        chk("t6_terr", timeout_err, 0);
        mem_done = 0; m1_en = 0;
        tick();
        chk("t6_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
